// File: rtl/fc_layer_seq_pkg.sv
// ============================================================================
// Module : fc_layer_seq_pkg
// Brief  : Shared widths, FSM state encoding and result saturation for the FC layer engine
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fc_layer_seq_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MAC   = 3'd2,
        S_FLUSH = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767)
            return 16'h7FFF;
        else if (v < -64'sd32768)
            return 16'h8000;
        else
            return v[DATA_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_layer_seq_if.sv
// ============================================================================
// Module : fc_layer_seq_if
// Brief  : Control, RAM and result-stream bundle between the engine and its environment
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fc_layer_seq_if;
    import fc_layer_seq_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;
    logic              res_valid;
    logic [15:0]       res_idx;
    logic [DATA_W-1:0] res_data;

    modport master (
        output start, ram_q,
        input  busy, done, ram_addr, ram_we, ram_data, res_valid, res_idx, res_data
    );

    modport slave (
        input  start, ram_q,
        output busy, done, ram_addr, ram_we, ram_data, res_valid, res_idx, res_data
    );

endinterface

`default_nettype wire

// File: rtl/fc_layer_seq_mac_dp.sv
// ============================================================================
// Module : fc_layer_seq_mac_dp
// Brief  : Signed 16x16 multiply-accumulate with clear, arithmetic shift and 16-bit saturation
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fc_layer_seq_mac_dp
    import fc_layer_seq_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int SHIFT = 0
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     i_clear,
    input  wire logic                     i_acc_en,
    input  wire logic signed [DATA_W-1:0] i_x,
    input  wire logic signed [DATA_W-1:0] i_w,
    output logic signed [DATA_W-1:0]      o_res
);

    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_shifted;

    assign w_prod    = i_x * i_w;
    assign w_shifted = r_acc >>> SHIFT;
    assign o_res     = sat16(64'(w_shifted));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_acc <= '0;
        else if (i_clear)
            r_acc <= '0;
        else if (i_acc_en)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

endmodule

`default_nettype wire

// File: rtl/fc_layer_seq.sv
// ============================================================================
// Module : fc_layer_seq
// Brief  : Loads activations, streams weights, computes and writes back BCK_CELL saturated dot products
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fc_layer_seq
    import fc_layer_seq_pkg::*;
#(
    parameter int FRT_CELL = 10,
    parameter int BCK_CELL = 5,
    parameter int IN_BASE  = 0,
    parameter int W_BASE   = 10,
    parameter int RES_BASE = 60,
    parameter int ACC_W    = 40,
    parameter int SHIFT    = 0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    fc_layer_seq_if.slave bus
);

    localparam logic [15:0] c_load_last = 16'(FRT_CELL);
    localparam logic [15:0] c_last_i    = 16'(FRT_CELL - 1);
    localparam logic [15:0] c_last_j    = 16'(BCK_CELL - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [15:0]               r_cnt;
    logic [15:0]               r_j;
    logic [ADDR_W-1:0]         r_waddr;
    logic signed [DATA_W-1:0]  r_x [FRT_CELL];
    logic                      w_clear;
    logic                      w_acc_en;
    logic                      w_x_shift;
    logic signed [DATA_W-1:0]  w_x_in;
    logic signed [DATA_W-1:0]  w_res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_j     <= '0;
            r_waddr <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_j     <= '0;
                    r_waddr <= ADDR_W'(W_BASE);
                end
                S_LOAD:  r_cnt <= (r_cnt == c_load_last) ? '0 : r_cnt + 16'd1;
                S_MAC: begin
                    r_cnt   <= r_cnt + 16'd1;
                    r_waddr <= r_waddr + 16'd1;
                end
                S_WB: begin
                    r_cnt <= '0;
                    r_j   <= r_j + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Activations live in a ring: LOAD shifts words in, each MAC step consumes
    // x[0] and rotates, so after FRT_CELL products the order is restored.
    assign w_x_in    = (r_state == S_LOAD) ? signed'(bus.ram_q) : r_x[0];
    assign w_x_shift = ((r_state == S_LOAD) && (r_cnt != 16'd0)) ||
                       ((r_state == S_MAC)  && (r_cnt != 16'd0)) ||
                        (r_state == S_FLUSH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < FRT_CELL; n++)
                r_x[n] <= '0;
        end else if (w_x_shift) begin
            for (int n = 0; n < FRT_CELL - 1; n++)
                r_x[n] <= r_x[n+1];
            r_x[FRT_CELL-1] <= w_x_in;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_clear       = 1'b0;
        w_acc_en      = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_data  = '0;
        bus.res_valid = 1'b0;
        bus.res_idx   = '0;
        bus.res_data  = '0;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_LOAD;
            S_LOAD: begin
                bus.busy = 1'b1;
                if (r_cnt == c_load_last)
                    w_next = S_MAC;
                else
                    bus.ram_addr = ADDR_W'(IN_BASE) + r_cnt;
            end
            S_MAC: begin
                bus.busy     = 1'b1;
                bus.ram_addr = r_waddr;
                w_clear      = (r_cnt == 16'd0);
                w_acc_en     = (r_cnt != 16'd0);
                if (r_cnt == c_last_i) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                bus.busy = 1'b1;
                w_acc_en = 1'b1;
                w_next   = S_WB;
            end
            S_WB: begin
                bus.busy      = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = ADDR_W'(RES_BASE) + r_j;
                bus.ram_data  = w_res;
                bus.res_valid = 1'b1;
                bus.res_idx   = r_j;
                bus.res_data  = w_res;
                w_next        = (r_j == c_last_j) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    fc_layer_seq_mac_dp #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_mac_dp (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_acc_en (w_acc_en),
        .i_x      (r_x[0]),
        .i_w      (signed'(bus.ram_q)),
        .o_res    (w_res)
    );

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_seq.sv
// ============================================================================
// Module : tb_fc_layer_seq
// Brief  : Scoreboard bench: two engines (SHIFT=0 and SHIFT=4) on private RAM models
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fc_layer_seq;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    logic clk;
    logic rst0;
    logic rst1;

    fc_layer_seq_if bus0 ();
    fc_layer_seq_if bus1 ();

    fc_layer_seq #(.SHIFT(0)) u_dut0 (.clk(clk), .reset(rst0), .bus(bus0));
    fc_layer_seq #(.SHIFT(4)) u_dut1 (.clk(clk), .reset(rst1), .bus(bus1));

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic        bk_we;
    logic [1:0]  bk_sel;
    logic [7:0]  bk_addr;
    logic [15:0] bk_data;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    int   rv0 = 0;
    int   dn0 = 0;

    int base_res [5]  = '{-12760, -11110, -9460, -7810, -6160};
    int shift_res [5] = '{-798, -695, -592, -489, -385};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: registered read, DUT write has priority over the backdoor
    always @(posedge clk) begin
        if (bus0.ram_we) mem0[bus0.ram_addr[7:0]] <= bus0.ram_data;
        else if (bk_we && bk_sel[0]) mem0[bk_addr] <= bk_data;
        bus0.ram_q <= mem0[bus0.ram_addr[7:0]];
        if (bus1.ram_we) mem1[bus1.ram_addr[7:0]] <= bus1.ram_data;
        else if (bk_we && bk_sel[1]) mem1[bk_addr] <= bk_data;
        bus1.ram_q <= mem1[bus1.ram_addr[7:0]];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus0.done) dn0++;
        if (bus0.res_valid) begin
            rv0++;
            if (q0.size() == 0) begin
                chk("res0_unexpected", int'(bus0.res_idx), -1);
            end else begin
                e = q0.pop_front();
                chk("res0_idx", int'(bus0.res_idx), e.idx);
                chk("res0_data", int'($signed(bus0.res_data)), e.data);
                chk("res0_wb_addr", int'(bus0.ram_addr), 60 + e.idx);
                chk("res0_wb_we", int'(bus0.ram_we), 1);
            end
        end
        if (bus1.res_valid) begin
            if (q1.size() == 0) begin
                chk("res1_unexpected", int'(bus1.res_idx), -1);
            end else begin
                e = q1.pop_front();
                chk("res1_idx", int'(bus1.res_idx), e.idx);
                chk("res1_data", int'($signed(bus1.res_data)), e.data);
            end
        end
    end

    task automatic push(input int u, input int j, input int d);
        exp_t e;
        e.idx  = j;
        e.data = d;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic bk_wr(input logic [1:0] sel, input int a, input int d);
        @(negedge clk);
        bk_we   = 1'b1;
        bk_sel  = sel;
        bk_addr = 8'(a);
        bk_data = 16'(d);
    endtask

    task automatic bk_end();
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    task automatic set_start(input int u, input logic v);
        if (u == 0) bus0.start = v;
        else        bus1.start = v;
    endtask

    // Accept cycle is cycle 0; returns the cycle index in which done is seen, -1 on timeout
    task automatic run(input int u, output int lat);
        int cyc;
        bit seen;
        @(negedge clk);
        set_start(u, 1'b1);
        @(posedge clk);
        #1;
        set_start(u, 1'b0);
        cyc  = 1;
        seen = 0;
        chk("busy_after_accept", int'((u == 0) ? bus0.busy : bus1.busy), 1);
        while (!seen && cyc < 300) begin
            if ((u == 0) ? bus0.done : bus1.done) begin
                seen = 1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (seen) chk("busy_at_done", int'((u == 0) ? bus0.busy : bus1.busy), 0);
        lat = seen ? cyc : -1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat;
        int rbase;
        int dbase;
        int wait_cyc;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        bk_we = 1'b0; bk_sel = 2'b00; bk_addr = '0; bk_data = '0;
        rst0 = 1'b0; rst1 = 1'b0;
        #2;
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_busy", int'(bus0.busy), 0);
        chk("rst_done", int'(bus0.done), 0);
        chk("rst_ram_we", int'(bus0.ram_we), 0);
        chk("rst_res_valid", int'(bus0.res_valid), 0);
        chk("rst_ram_addr", int'(bus0.ram_addr), 0);
        chk("rst_ram_data", int'(bus0.ram_data), 0);
        chk("rst_res_idx", int'(bus0.res_idx), 0);
        chk("rst_res_data", int'(bus0.res_data), 0);

        for (int k = 0; k < 10; k++) bk_wr(2'b11, k, k + 1);
        for (int k = 0; k < 50; k++) bk_wr(2'b11, 10 + k, -250 + 3 * k);
        bk_end();
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        // Two back-to-back runs on default data must match
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 5; j++) push(0, j, base_res[j]);
            run(0, lat);
            chk("latency", lat, 72);
            for (int j = 0; j < 5; j++) chk("ram_result", int'($signed(mem0[60 + j])), base_res[j]);
            chk("q0_drained", q0.size(), 0);
        end

        for (int j = 0; j < 5; j++) push(1, j, shift_res[j]);
        run(1, lat);
        chk("latency_shift", lat, 72);
        chk("ram_result_shift0", int'($signed(mem1[60])), -798);
        chk("q1_drained", q1.size(), 0);

        // A second start mid-run must be ignored
        rbase = rv0;
        dbase = dn0;
        for (int j = 0; j < 5; j++) push(0, j, base_res[j]);
        @(negedge clk); bus0.start = 1'b1;
        @(negedge clk); bus0.start = 1'b0;
        repeat (15) @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk); bus0.start = 1'b0;
        repeat (150) @(negedge clk);
        chk("ignored_start_res_count", rv0 - rbase, 5);
        chk("ignored_start_done_count", dn0 - dbase, 1);
        chk("q0_drained_ignored", q0.size(), 0);

        // Reset during neuron 2 MAC: no write-back to RAM[62]
        bk_wr(2'b01, 62, 16'h1234);
        bk_end();
        rbase = rv0;
        push(0, 0, base_res[0]);
        push(0, 1, base_res[1]);
        @(negedge clk); bus0.start = 1'b1;
        @(negedge clk); bus0.start = 1'b0;
        wait_cyc = 0;
        while (rv0 < rbase + 2 && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("reach_neuron2", int'(rv0 >= rbase + 2), 1);
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        #1;
        chk("midrst_busy", int'(bus0.busy), 0);
        chk("midrst_ram_we", int'(bus0.ram_we), 0);
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_write62", int'(mem0[62]), 32'h1234);
        chk("midrst_res_count", rv0 - rbase, 2);
        chk("q0_drained_midrst", q0.size(), 0);
        for (int j = 0; j < 5; j++) push(0, j, base_res[j]);
        run(0, lat);
        chk("latency_after_rst", lat, 72);
        chk("ram_result62_after_rst", int'($signed(mem0[62])), -9460);

        // Saturation: only x[0] nonzero, so result j = 32767 * w(j,0)
        bk_wr(2'b01, 0, 32767);
        for (int k = 1; k < 10; k++) bk_wr(2'b01, k, 0);
        bk_wr(2'b01, 10, 32767);
        bk_end();
        push(0, 0, 32767);
        for (int j = 1; j < 5; j++) push(0, j, -32768);
        run(0, lat);
        chk("ram_sat_pos", int'($signed(mem0[60])), 32767);

        bk_wr(2'b01, 10, 16'h8000);
        bk_end();
        for (int j = 0; j < 5; j++) push(0, j, -32768);
        run(0, lat);
        chk("ram_sat_neg", int'($signed(mem0[60])), -32768);
        chk("q0_drained_sat", q0.size(), 0);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
